// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/off events onto a bank of envelope voices,
// stealing the oldest voice when none is free and retriggering voices through a one-cycle gate drop.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_WIDTH = 7,
  parameter int AGE_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             note_valid,
  output logic                             note_ready,
  input  logic                             note_on,
  input  logic [NOTE_WIDTH-1:0]            note_num,
  input  logic [NUM_VOICES-1:0]            env_idle,
  output logic [NUM_VOICES-1:0]            voice_gate,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
  output logic                             steal_pulse,
  output logic [$clog2(NUM_VOICES+1)-1:0]  active_count
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(NUM_VOICES+1);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  typedef enum logic {READY, STEAL} state_t;

  state_t                  state, state_nxt;
  logic [NUM_VOICES-1:0]   gate, gate_nxt;
  logic [NOTE_WIDTH-1:0]   note     [NUM_VOICES];
  logic [NOTE_WIDTH-1:0]   note_nxt [NUM_VOICES];
  logic [AGE_WIDTH-1:0]    age      [NUM_VOICES];
  logic [AGE_WIDTH-1:0]    age_nxt  [NUM_VOICES];
  logic [IW-1:0]           steal_idx, steal_idx_nxt;
  logic                    steal_nxt;
  logic [CW-1:0]           count_nxt;
  logic                    accept;

  logic                    has_match, has_free, has_rel, has_old, sel_free;
  logic [IW-1:0]           match_idx, free_idx, rel_idx, old_idx, sel;
  logic [AGE_WIDTH-1:0]    rel_age, old_age;

  assign accept = note_valid && note_ready;

  // Voice selection: scan ascending with strict '>' so age ties resolve to the lowest index.
  // NOTE: combinational blocks use blocking '=' and assign every output a default first,
  // so no latches are inferred; clocked blocks use non-blocking '<=' only.
  always_comb begin
    has_match = 1'b0; match_idx = '0;
    has_free  = 1'b0; free_idx  = '0;
    has_rel   = 1'b0; rel_idx   = '0; rel_age = '0;
    has_old   = 1'b0; old_idx   = '0; old_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate[i]) begin
        if (!has_match && note[i] == note_num) begin
          has_match = 1'b1;
          match_idx = IW'(i);
        end
        if (!has_old || age[i] > old_age) begin
          has_old = 1'b1;
          old_idx = IW'(i);
          old_age = age[i];
        end
      end else if (env_idle[i]) begin
        if (!has_free) begin
          has_free = 1'b1;
          free_idx = IW'(i);
        end
      end else if (!has_rel || age[i] > rel_age) begin
        has_rel = 1'b1;
        rel_idx = IW'(i);
        rel_age = age[i];
      end
    end
    sel_free = 1'b0;
    if (has_match)     sel = match_idx;
    else if (has_free) begin
      sel      = free_idx;
      sel_free = 1'b1;
    end
    else if (has_rel)  sel = rel_idx;
    else               sel = old_idx;
  end

  // Datapath next state: every effect of an accepted event lands on one edge.
  always_comb begin
    gate_nxt      = gate;
    note_nxt      = note;
    age_nxt       = age;
    steal_idx_nxt = steal_idx;
    steal_nxt     = 1'b0;
    if (state == STEAL) begin
      gate_nxt[steal_idx] = 1'b1;
    end else if (accept) begin
      if (note_on) begin
        for (int i = 0; i < NUM_VOICES; i++)
          age_nxt[i] = (age[i] == AGE_MAX) ? age[i] : age[i] + AGE_WIDTH'(1);
        age_nxt[sel]  = '0;
        note_nxt[sel] = note_num;
        if (sel_free) begin
          gate_nxt[sel] = 1'b1;
        end else begin
          gate_nxt[sel] = 1'b0;
          steal_idx_nxt = sel;
          steal_nxt     = 1'b1;
        end
      end else begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (gate[i] && note[i] == note_num) gate_nxt[i] = 1'b0;
      end
    end
    count_nxt = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      count_nxt = count_nxt + CW'(gate_nxt[i]);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= READY;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      READY: if (accept && note_on && !sel_free) state_nxt = STEAL;
      STEAL: state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    note_ready = (state == READY);
  end

  // NOTE: the note and age arrays are reset explicitly because their values are
  // architecturally visible (voice_note) or steer stealing right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate         <= '0;
      steal_idx    <= '0;
      steal_pulse  <= 1'b0;
      active_count <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note[i] <= '0;
        age[i]  <= '0;
      end
    end else begin
      gate         <= gate_nxt;
      note         <= note_nxt;
      age          <= age_nxt;
      steal_idx    <= steal_idx_nxt;
      steal_pulse  <= steal_nxt;
      active_count <= count_nxt;
    end
  end

  assign voice_gate = gate;

  always_comb begin
    voice_note = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      voice_note[i*NOTE_WIDTH +: NOTE_WIDTH] = note[i];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized bench for voice_allocator: directed scenarios plus random events, all checked
// cycle by cycle against an event-level reference model of the voice allocation rules.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int NW = 7;
  localparam int AW = 8;
  localparam int AGE_SAT = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              note_valid;
  logic              note_ready;
  logic              note_on;
  logic [NW-1:0]     note_num;
  logic [NV-1:0]     env_idle;
  logic [NV-1:0]     voice_gate;
  logic [NV*NW-1:0]  voice_note;
  logic              steal_pulse;
  logic [2:0]        active_count;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .AGE_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
    .note_on(note_on), .note_num(note_num), .env_idle(env_idle),
    .voice_gate(voice_gate), .voice_note(voice_note), .steal_pulse(steal_pulse),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, one entry per voice
  bit          m_gate [NV];
  logic [NW-1:0] m_note [NV];
  int          m_age  [NV];
  bit          m_pend;
  int          m_pidx;
  bit          m_pulse;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Score each voice: class rank dominates, then age (steal classes only), then lower index.
  task automatic pick(input logic [NW-1:0] num, input logic [NV-1:0] idle,
                      output int sel, output int cls);
    int best = -1;
    sel = 0; cls = 0;
    for (int i = 0; i < NV; i++) begin
      int c, score;
      if (m_gate[i] && m_note[i] == num) c = 1;
      else if (!m_gate[i] && idle[i])    c = 2;
      else if (!m_gate[i])               c = 3;
      else                               c = 4;
      score = (5 - c) * 100000 + ((c >= 3) ? m_age[i] * 100 : 0) + (99 - i);
      if (score > best) begin
        best = score; sel = i; cls = c;
      end
    end
  endtask

  task automatic model_step(input bit r, input bit acc, input bit on,
                            input logic [NW-1:0] num, input logic [NV-1:0] idle);
    int sel, cls;
    if (r) begin
      for (int i = 0; i < NV; i++) begin
        m_gate[i] = 0; m_note[i] = '0; m_age[i] = 0;
      end
      m_pend = 0; m_pidx = 0; m_pulse = 0;
    end else if (m_pend) begin
      m_gate[m_pidx] = 1; m_pend = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (acc && on) begin
        pick(num, idle, sel, cls);
        for (int i = 0; i < NV; i++)
          if (i != sel) m_age[i] = (m_age[i] + 1 > AGE_SAT) ? AGE_SAT : m_age[i] + 1;
        m_age[sel]  = 0;
        m_note[sel] = num;
        if (cls == 2) m_gate[sel] = 1;
        else begin
          m_gate[sel] = 0; m_pend = 1; m_pidx = sel; m_pulse = 1;
        end
      end else if (acc) begin
        for (int i = 0; i < NV; i++)
          if (m_gate[i] && m_note[i] == num) m_gate[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [NV-1:0]    eg;
    logic [NV*NW-1:0] en;
    int cnt = 0;
    for (int i = 0; i < NV; i++) begin
      eg[i] = m_gate[i];
      en[i*NW +: NW] = m_note[i];
      cnt += int'(m_gate[i]);
    end
    check("note_ready", note_ready, !m_pend);
    check("voice_gate", voice_gate, eg);
    check("voice_note", voice_note, en);
    check("steal_pulse", steal_pulse, m_pulse);
    check("active_count", active_count, cnt);
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic cycle(input bit v, input bit on, input logic [NW-1:0] num,
                       input logic [NV-1:0] idle, input bit r, output bit acc);
    rst = r; note_valid = v; note_on = on; note_num = num; env_idle = idle;
    acc = v && !m_pend && !r;
    @(posedge clk);
    model_step(r, acc, on, num, idle);
    @(negedge clk);
    compare_all();
  endtask

  // Present an event and hold it stable until accepted (at most one stall cycle expected).
  task automatic send(input bit on, input logic [NW-1:0] num, input logic [NV-1:0] idle);
    bit acc = 0;
    for (int k = 0; k < 4 && !acc; k++) cycle(1, on, num, idle, 0, acc);
  endtask

  task automatic idle_cycle(input logic [NV-1:0] idle);
    bit acc;
    cycle(0, 0, '0, idle, 0, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst = 1; note_valid = 0; note_on = 0; note_num = '0; env_idle = '1;
    m_pend = 0; m_pidx = 0; m_pulse = 0;
    @(negedge clk);
    cycle(0, 0, '0, '1, 1, acc);
    cycle(0, 0, '0, '1, 1, acc);
    idle_cycle('1);

    // Fill all four voices from free slots
    send(1, 7'd60, 4'b1111);
    check("gate_after_1", voice_gate, 4'b0001);
    send(1, 7'd62, 4'b1111);
    send(1, 7'd64, 4'b1111);
    send(1, 7'd67, 4'b1111);
    check("gates_full", voice_gate, 4'b1111);
    check("notes_full", voice_note, {7'd67, 7'd64, 7'd62, 7'd60});

    // Steal oldest (voice 0)
    send(1, 7'd72, 4'b0000);
    check("steal_gate_low", voice_gate, 4'b1110);
    idle_cycle('0);
    check("steal_gate_back", voice_gate, 4'b1111);

    // Release voice 1, then it is chosen as the releasing voice
    send(0, 7'd62, 4'b0000);
    send(1, 7'd74, 4'b1101);
    idle_cycle('0);
    check("rel_steal_note", voice_note[NW +: NW], 7'd74);

    // Retrigger an already-gated note, then a note-off with no match
    send(1, 7'd64, 4'b0000);
    idle_cycle('0);
    send(0, 7'd99, 4'b0000);

    // Drive ages into saturation by retriggering voice 3 many times, then voice 2 a few times
    for (int k = 0; k < 300; k++) send(1, 7'd67, 4'b0000);
    for (int k = 0; k < 10; k++)  send(1, 7'd64, 4'b0000);
    send(1, 7'd50, 4'b0000);
    idle_cycle('0);
    check("sat_steal_voice0", voice_note[0 +: NW], 7'd50);

    // Reset during the STEAL cycle discards the latched steal
    send(1, 7'd51, 4'b0000);
    cycle(0, 0, '0, '0, 1, acc);
    check("rst_steal_gate", voice_gate, '0);
    idle_cycle('1);

    // Random traffic over a narrow note range so matches and steals are frequent
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0)
        idle_cycle(NV'($urandom));
      else
        send($urandom_range(0, 9) < 6, NW'(60 + $urandom_range(0, 7)), NV'($urandom));
    end
    idle_cycle('0);
    idle_cycle('0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
